// File: rtl/gbe_tx_pkt_scheduler_pkg.sv
// Shared definitions for the 10GbE transmit packet scheduler: FSM states,
// header word layout and the source-read to transmit latency.
package gbe_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Header word: {seq, source id, reserved byte}, left-aligned in 64 bits.
  localparam int HDR_W     = 64;
  localparam int SEQ_W_DEF = 48;
  localparam int SRC_ID_W  = 8;
  localparam int RSVD_W    = 8;
  localparam int SEQ_MAX_W = HDR_W - SRC_ID_W - RSVD_W;

  localparam logic [RSVD_W-1:0] HDR_RSVD = '0;

  // Cycles from a source read strobe to the matching tx_valid beat.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/gbe_tx_pkt_scheduler_if.sv
// Transmit-side bus between the scheduler and the 10GbE core.
interface gbe_tx_pkt_scheduler_if;
  import gbe_sched_pkg::*;

  logic             tx_valid;
  logic [HDR_W-1:0] tx_data;
  logic             tx_end_of_frame;
  logic [31:0]      tx_dest_ip;
  logic [15:0]      tx_dest_port;
  logic             tx_afull;
  logic             tx_overflow;

  modport master (
    output tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
    input  tx_afull, tx_overflow
  );

  modport slave (
    input  tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
    output tx_afull, tx_overflow
  );

endinterface

// File: rtl/gbe_tx_pkt_scheduler_rr_arbiter.sv
// Combinational round-robin search: grants the first requester above the
// previously served index, wrapping at N. The last index is registered by
// the parent; gnt is only driven while load is high, idx always reflects
// the search result.
module rr_arbiter
  import gbe_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          load,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk last+1, last+2, ... modulo N and take the first set request
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = load;
      end
    end
  end

endmodule

// File: rtl/gbe_tx_pkt_scheduler.sv
// Round-robin packet scheduler sharing one 10GbE transmit port between
// N_SRC packet FIFOs. Each packet is a header word followed by
// PAYLOAD_WORDS words read from the granted source; reads pause while the
// core signals almost-full.
module gbe_tx_pkt_scheduler
  import gbe_sched_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int PAYLOAD_WORDS = 128,
  parameter int SEQ_W         = SEQ_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_SRC-1:0]      src_pkt_avail,
  output logic [N_SRC-1:0]      src_rd,
  input  logic [N_SRC*64-1:0]   src_data,
  input  logic [31:0]           dest_ip_base,
  input  logic [15:0]           dest_port,
  gbe_tx_pkt_scheduler_if.master tx,
  output logic                  busy,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           overflow_cnt
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WC_W  = $clog2(PAYLOAD_WORDS);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(PAYLOAD_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    g_q, last_q;
  logic [WC_W-1:0]     wc_q;
  logic [SEQ_W-1:0]    seq_q;
  logic [31:0]         dest_ip_q;
  logic [15:0]         dest_port_q;
  logic [31:0]         pkt_cnt_q;
  logic [15:0]         ovf_cnt_q;

  logic                vld_p0_q, eof_p0_q;
  logic                tx_valid_q, tx_eof_q;
  logic [HDR_W-1:0]    tx_data_q;

  logic                arb_load;
  logic [N_SRC-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;

  logic                grant, hdr_fire, rd_fire, rd_last, pkt_done;
  logic [HDR_W-1:0]    src_word [N_SRC];

  function automatic logic [HDR_W-1:0] build_hdr(input logic [SEQ_W-1:0] seq,
                                                  input logic [IDX_W-1:0] id);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_W-1 -: SEQ_W]                            = seq;
    h[HDR_W-1-SEQ_W -: SRC_ID_W]                   = SRC_ID_W'(id);
    h[HDR_W-1-SEQ_W-SRC_ID_W -: RSVD_W]            = HDR_RSVD;
    return h;
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*64 +: 64];
  end

  // The arbiter only searches while idle and enabled; en is ignored mid-packet
  assign arb_load = (state_q == ST_IDLE) && en;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req  (src_pkt_avail),
    .last (last_q),
    .load (arb_load),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Next-state and per-cycle strobes for the packet sequencer
  always_comb begin
    state_d  = state_q;
    src_rd   = '0;
    grant    = 1'b0;
    hdr_fire = 1'b0;
    rd_fire  = 1'b0;
    rd_last  = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          grant   = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!tx.tx_afull) begin
          hdr_fire = 1'b1;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!tx.tx_afull) begin
          rd_fire = 1'b1;
          src_rd  = N_SRC'(1) << g_q;
          if (wc_q == WC_LAST) begin
            rd_last = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Close the packet in the cycle its EOF beat is on the bus
        if (tx_eof_q) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, grant bookkeeping and software-visible counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      last_q      <= IDX_LAST;
      wc_q        <= '0;
      seq_q       <= '0;
      dest_ip_q   <= '0;
      dest_port_q <= '0;
      pkt_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        g_q         <= arb_idx;
        dest_ip_q   <= dest_ip_base + 32'(arb_idx);
        dest_port_q <= dest_port;
      end
      if (hdr_fire) begin
        wc_q <= '0;
      end else if (rd_fire) begin
        wc_q <= wc_q + WC_W'(1);
      end
      if (pkt_done) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
        seq_q     <= seq_q + SEQ_W'(1);
        last_q    <= g_q;
      end
      if (tx.tx_overflow && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  // Stage p0: tag the read issued this cycle; its source word arrives next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      eof_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= rd_fire;
      eof_p0_q <= rd_last;
    end
  end

  // Output stage: register either the header or the returned payload word
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_eof_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= vld_p0_q | hdr_fire;
      tx_eof_q   <= eof_p0_q;
      if (vld_p0_q) begin
        tx_data_q <= src_word[g_q];
      end else if (hdr_fire) begin
        tx_data_q <= build_hdr(seq_q, g_q);
      end
    end
  end

  assign tx.tx_valid        = tx_valid_q;
  assign tx.tx_data         = tx_data_q;
  assign tx.tx_end_of_frame = tx_eof_q;
  assign tx.tx_dest_ip      = dest_ip_q;
  assign tx.tx_dest_port    = dest_port_q;

  assign busy         = (state_q != ST_IDLE);
  assign pkt_cnt      = pkt_cnt_q;
  assign overflow_cnt = ovf_cnt_q;

endmodule
